// File: rtl/iter_branch_cmp.sv
// Multi-cycle branch/set comparator: scans operands MSB-first, one CHUNK-bit slice per cycle,
// and produces eq/lt/taken for eight branch/set compare modes.
module iter_branch_cmp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             taken
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  // One-hot-ish encoding so busy/done come straight off state flops
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [2:0] M_BEQ  = 3'b000;
  localparam logic [2:0] M_BNE  = 3'b001;
  localparam logic [2:0] M_BLEZ = 3'b010;
  localparam logic [2:0] M_BGTZ = 3'b011;
  localparam logic [2:0] M_BLTZ = 3'b100;
  localparam logic [2:0] M_BGEZ = 3'b101;
  localparam logic [2:0] M_SLT  = 3'b110;
  localparam logic [2:0] M_SLTU = 3'b111;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("iter_branch_cmp: WIDTH must be a multiple of CHUNK");
  end

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       mode_r;
  logic [IDXW-1:0]  idx_r;
  logic             eq_acc_r;
  logic             lt_acc_r;
  logic             eq_r;
  logic             lt_r;
  logic             taken_r;

  logic [WIDTH-1:0] b_eff_s;
  logic [CHUNK-1:0] a_slice_s;
  logic [CHUNK-1:0] b_slice_s;
  logic [CHUNK-1:0] a_cmp_s;
  logic [CHUNK-1:0] b_cmp_s;
  logic             is_signed_s;
  logic             is_eqne_s;
  logic             eq_acc_nxt_s;
  logic             lt_acc_nxt_s;
  logic             lt_res_s;
  logic             taken_res_s;

  // Effective B: compare-against-zero modes ignore operand B
  always_comb begin
    if ((mode[2] ^ mode[1]) == 1'b1) begin
      b_eff_s = '0;
    end else begin
      b_eff_s = inputB;
    end
  end

  // Mode classification for the latched operation
  always_comb begin
    is_eqne_s   = (mode_r == M_BEQ) || (mode_r == M_BNE);
    is_signed_s = !is_eqne_s && (mode_r != M_SLTU);
  end

  // AND-OR slice mux selected by idx_r
  always_comb begin
    a_slice_s = '0;
    b_slice_s = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      a_slice_s = a_slice_s | ({CHUNK{idx_r == IDXW'(i)}} & a_r[i*CHUNK +: CHUNK]);
      b_slice_s = b_slice_s | ({CHUNK{idx_r == IDXW'(i)}} & b_r[i*CHUNK +: CHUNK]);
    end
  end

  // Flipping the sign bit of the top slice turns a signed compare into an unsigned one
  always_comb begin
    if (is_signed_s && (idx_r == IDX_LAST)) begin
      a_cmp_s = a_slice_s ^ MSB_MASK;
      b_cmp_s = b_slice_s ^ MSB_MASK;
    end else begin
      a_cmp_s = a_slice_s;
      b_cmp_s = b_slice_s;
    end
  end

  // Accumulator update: the first differing slice decides the result
  always_comb begin
    eq_acc_nxt_s = eq_acc_r;
    lt_acc_nxt_s = lt_acc_r;
    if (eq_acc_r && (a_cmp_s < b_cmp_s)) begin
      eq_acc_nxt_s = 1'b0;
      lt_acc_nxt_s = 1'b1;
    end else if (eq_acc_r && (a_cmp_s > b_cmp_s)) begin
      eq_acc_nxt_s = 1'b0;
      lt_acc_nxt_s = lt_acc_r;
    end else begin
      eq_acc_nxt_s = eq_acc_r;
      lt_acc_nxt_s = lt_acc_r;
    end
  end

  // Final result decode from the accumulators after the last slice
  always_comb begin
    if (is_eqne_s) begin
      lt_res_s = 1'b0;
    end else begin
      lt_res_s = lt_acc_nxt_s;
    end
    case (mode_r)
      M_BEQ:   taken_res_s = eq_acc_nxt_s;
      M_BNE:   taken_res_s = !eq_acc_nxt_s;
      M_BLEZ:  taken_res_s = lt_res_s | eq_acc_nxt_s;
      M_BGTZ:  taken_res_s = !lt_res_s & !eq_acc_nxt_s;
      M_BLTZ:  taken_res_s = lt_res_s;
      M_BGEZ:  taken_res_s = !lt_res_s;
      M_SLT:   taken_res_s = lt_res_s;
      M_SLTU:  taken_res_s = lt_res_s;
      default: taken_res_s = 1'b0;
    endcase
  end

  // Control FSM, operand latches, accumulators and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      mode_r   <= 3'b000;
      idx_r    <= '0;
      eq_acc_r <= 1'b0;
      lt_acc_r <= 1'b0;
      eq_r     <= 1'b0;
      lt_r     <= 1'b0;
      taken_r  <= 1'b0;
    end else if (flush) begin
      state_r <= S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_r      <= inputA;
            b_r      <= b_eff_s;
            mode_r   <= mode;
            idx_r    <= IDX_LAST;
            eq_acc_r <= 1'b1;
            lt_acc_r <= 1'b0;
            state_r  <= S_BUSY;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_BUSY: begin
          eq_acc_r <= eq_acc_nxt_s;
          lt_acc_r <= lt_acc_nxt_s;
          if (idx_r == '0) begin
            eq_r    <= eq_acc_nxt_s;
            lt_r    <= lt_res_s;
            taken_r <= taken_res_s;
            state_r <= S_DONE;
          end else begin
            idx_r <= idx_r - 1'b1;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign busy  = state_r[0];
  assign done  = state_r[1];
  assign eq    = eq_r;
  assign lt    = lt_r;
  assign taken = taken_r;

endmodule

// File: tb/tb_iter_branch_cmp.sv
// Directed bench for iter_branch_cmp: default 8-bit chunks plus a CHUNK=WIDTH instance.
module tb_iter_branch_cmp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  mode;
  logic [31:0] ina, inb;
  logic        busy, done, eq, lt, taken;

  logic        start_w, flush_w;
  logic [2:0]  mode_w;
  logic [31:0] ina_w, inb_w;
  logic        busy_w, done_w, eq_w, lt_w, taken_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iter_branch_cmp #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .mode(mode),
    .inputA(ina), .inputB(inb), .busy(busy), .done(done), .eq(eq), .lt(lt), .taken(taken)
  );

  iter_branch_cmp #(.WIDTH(32), .CHUNK(32)) u_wide (
    .clk(clk), .rst_n(rst_n), .start(start_w), .flush(flush_w), .mode(mode_w),
    .inputA(ina_w), .inputB(inb_w), .busy(busy_w), .done(done_w), .eq(eq_w), .lt(lt_w),
    .taken(taken_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one compare on the 8-bit-chunk instance and check latency, busy length and results
  task automatic run_op(input string tag, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic e_eq, input logic e_lt,
                        input logic e_tk);
    int n;
    int bc;
    mode = m; ina = a; inb = b; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 32'd4);
    chk({tag, "_busycnt"}, bc, 32'd4);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_eq"}, {31'd0, eq}, {31'd0, e_eq});
    chk({tag, "_lt"}, {31'd0, lt}, {31'd0, e_lt});
    chk({tag, "_taken"}, {31'd0, taken}, {31'd0, e_tk});
  endtask

  initial begin
    int n;
    int dcnt;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; mode = 3'b000; ina = 32'd0; inb = 32'd0;
    start_w = 1'b0; flush_w = 1'b0; mode_w = 3'b000; ina_w = 32'd0; inb_w = 32'd0;
    #1;
    chk("rst_outs", {27'd0, busy, done, eq, lt, taken}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_outs", {27'd0, busy, done, eq, lt, taken}, 32'd0);

    run_op("beq", 3'b000, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b1);
    chk("beq_done", {31'd0, done}, 32'd1);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    run_op("bne", 3'b001, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0);
    run_op("beq_lowdiff", 3'b000, 32'h12345678, 32'h12345679, 1'b0, 1'b0, 1'b0);
    run_op("slt", 3'b110, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b1);
    run_op("sltu", 3'b111, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op("slt_pos", 3'b110, 32'h00000005, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_op("blez", 3'b010, 32'h80000000, 32'h00000007, 1'b0, 1'b1, 1'b1);
    run_op("bgtz", 3'b011, 32'h00000000, 32'h00000009, 1'b1, 1'b0, 1'b0);
    run_op("bltz", 3'b100, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1);
    run_op("bgez", 3'b101, 32'h00000100, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);

    // start in the 2nd BUSY cycle must be ignored
    mode = 3'b000; ina = 32'h00000001; inb = 32'h00000001; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mode = 3'b001; start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dcnt++;
      tick();
    end
    chk("ignore_start_dones", dcnt, 32'd1);
    chk("ignore_start_taken", {31'd0, taken}, 32'd1);

    // start held through DONE: back-to-back compare
    mode = 3'b000; ina = 32'hA5A5A5A5; inb = 32'hA5A5A5A5; start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("held_lat1", n, 32'd4);
    chk("held_eq1", {31'd0, eq}, 32'd1);
    mode = 3'b111; ina = 32'd3; inb = 32'd5;
    tick();
    n = 1;
    start = 1'b0;
    chk("held_busy2", {31'd0, busy}, 32'd1);
    while (!done && n < 20) begin tick(); n++; end
    chk("held_gap", n, 32'd5);
    chk("held_res2", {29'd0, eq, lt, taken}, 32'b011);

    // flush in 2nd BUSY cycle: back to IDLE, no done, results retained
    mode = 3'b000; ina = 32'd0; inb = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {30'd0, busy, done}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) dcnt++;
      tick();
    end
    chk("flush_no_done", dcnt, 32'd0);
    chk("flush_keep", {29'd0, eq, lt, taken}, 32'b011);

    // flush with start in IDLE: start dropped
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("flush_start_idle", {30'd0, busy, done}, 32'd0);

    // asynchronous reset in the middle of BUSY
    mode = 3'b000; ina = 32'd5; inb = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midbusy_rst", {27'd0, busy, done, eq, lt, taken}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
    run_op("post_rst", 3'b000, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b1);

    // CHUNK == WIDTH: single BUSY cycle
    mode_w = 3'b111; ina_w = 32'd3; inb_w = 32'd5; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    chk("wide_busy", {30'd0, busy_w, done_w}, 32'b10);
    tick();
    chk("wide_done", {30'd0, busy_w, done_w}, 32'b01);
    chk("wide_sltu", {29'd0, eq_w, lt_w, taken_w}, 32'b011);
    mode_w = 3'b110; ina_w = 32'hFFFFFFFF; inb_w = 32'h00000001; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    tick();
    chk("wide_slt_done", {31'd0, done_w}, 32'd1);
    chk("wide_slt", {29'd0, eq_w, lt_w, taken_w}, 32'b011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
